hazard_control: RTL and testbench

//  Pipeline stall/flush controller, directly downstream of the forwarding unit.

---
 rtl/hazard_control_if.sv | 41 ++++
 rtl/hazard_control.sv | 95 +++++++++
 tb/tb_hazard_control.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_if.sv
// Pipeline hazard-control bundle: hazard sources and cache handshakes in,
// stage enables, flushes, perf counters and watchdog flag out.
interface hazard_control_if #(
    parameter int CNT_W = 32
);
    logic             stall_lw;
    logic             br_mispredict;
    logic             icache_req;
    logic             icache_resp;
    logic             dcache_req;
    logic             dcache_resp;
    logic             perf_clr;
    logic             load_pc;
    logic             pc_redirect;
    logic             load_ifid;
    logic             load_idex;
    logic             load_exmem;
    logic             load_memwb;
    logic             flush_ifid;
    logic             flush_idex;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output stall_lw, br_mispredict, icache_req, icache_resp,
               dcache_req, dcache_resp, perf_clr,
        input  load_pc, pc_redirect, load_ifid, load_idex, load_exmem,
               load_memwb, flush_ifid, flush_idex,
               lu_stall_cnt, mem_stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  stall_lw, br_mispredict, icache_req, icache_resp,
               dcache_req, dcache_resp, perf_clr,
        output load_pc, pc_redirect, load_ifid, load_idex, load_exmem,
               load_memwb, flush_ifid, flush_idex,
               lu_stall_cnt, mem_stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline stall/flush controller with saturating hazard counters and a
// sticky memory-wait watchdog.
module hazard_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_control_if.slave hc
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [0:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_ctr_q, wait_ctr_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic [CNT_W-1:0]  fl_cnt_q, fl_cnt_d;
    logic              mem_busy;
    logic              case_redirect;
    logic              case_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic           en);
        if (en && (v != '1)) return v + CNT_W'(1);
        return v;
    endfunction

    // A busy cache freezes the whole pipe, so a pending redirect or load-use
    // bubble simply waits for the first non-busy cycle.
    assign mem_busy      = (hc.icache_req & ~hc.icache_resp) |
                           (hc.dcache_req & ~hc.dcache_resp);
    assign case_redirect = ~mem_busy & hc.br_mispredict;
    assign case_bubble   = ~mem_busy & ~hc.br_mispredict & hc.stall_lw;

    // rst_n gating keeps every control output low while reset is held.
    assign hc.load_pc     = rst_n & ~mem_busy & ~case_bubble;
    assign hc.load_ifid   = rst_n & ~mem_busy & ~case_bubble;
    assign hc.load_idex   = rst_n & ~mem_busy;
    assign hc.load_exmem  = rst_n & ~mem_busy;
    assign hc.load_memwb  = rst_n & ~mem_busy;
    assign hc.pc_redirect = rst_n & case_redirect;
    assign hc.flush_ifid  = rst_n & case_redirect;
    assign hc.flush_idex  = rst_n & (case_redirect | case_bubble);

    assign hc.lu_stall_cnt  = lu_cnt_q;
    assign hc.mem_stall_cnt = ms_cnt_q;
    assign hc.flush_cnt     = fl_cnt_q;
    assign hc.mem_timeout   = mem_timeout_q;

    always_comb begin
        state_d    = mem_busy ? ST_MEM_WAIT : ST_RUN;
        wait_ctr_d = '0;
        if (mem_busy) begin
            if (state_q == ST_RUN)
                wait_ctr_d = WAIT_W'(1);
            else if (wait_ctr_q != WAIT_MAX)
                wait_ctr_d = wait_ctr_q + WAIT_W'(1);
            else
                wait_ctr_d = wait_ctr_q;
        end
        mem_timeout_d = mem_timeout_q | (wait_ctr_d == WAIT_MAX);

        if (hc.perf_clr) begin
            lu_cnt_d = '0;
            ms_cnt_d = '0;
            fl_cnt_d = '0;
        end else begin
            lu_cnt_d = sat_inc(lu_cnt_q, case_bubble);
            ms_cnt_d = sat_inc(ms_cnt_q, mem_busy);
            fl_cnt_d = sat_inc(fl_cnt_q, case_redirect);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_ctr_q    <= '0;
            mem_timeout_q <= 1'b0;
            lu_cnt_q      <= '0;
            ms_cnt_q      <= '0;
            fl_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            wait_ctr_q    <= wait_ctr_d;
            mem_timeout_q <= mem_timeout_d;
            lu_cnt_q      <= lu_cnt_d;
            ms_cnt_q      <= ms_cnt_d;
            fl_cnt_q      <= fl_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: vector table, directed corner sequences and
// random traffic against a cycle-level reference model.
module tb_hazard_control;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int CMAX    = 15;

    // Control vector order: {load_pc, pc_redirect, load_ifid, load_idex,
    //                        load_exmem, load_memwb, flush_ifid, flush_idex}
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;
    localparam logic [7:0] C_REDIR  = 8'b1111_1111;
    localparam logic [7:0] C_BUBBLE = 8'b0001_1101;
    localparam logic [7:0] C_RUN    = 8'b1011_1100;

    // Input vector order: {stall_lw, br_mispredict, icache_req, icache_resp,
    //                      dcache_req, dcache_resp}
    typedef struct {
        logic [5:0] in;
        logic [7:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int   cnt [1:3];      // indexed by case: 1 mem stall, 2 flush, 3 load-use
    int   m_wait;
    bit   m_to;
    vec_t tbl [10];

    always #5 clk = ~clk;

    hazard_control_if #(.CNT_W(CNT_W)) hif ();

    hazard_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hc    (hif.slave)
    );

    function automatic int kind_of(logic [5:0] v);
        bit busy;
        busy = (v[3] && !v[2]) || (v[1] && !v[0]);
        if (busy) return 1;
        if (v[4]) return 2;
        if (v[5]) return 3;
        return 4;
    endfunction

    function automatic logic [7:0] ctrl_of(int k);
        case (k)
            1:       return C_FREEZE;
            2:       return C_REDIR;
            3:       return C_BUBBLE;
            default: return C_RUN;
        endcase
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {hif.load_pc, hif.pc_redirect, hif.load_ifid, hif.load_idex,
                hif.load_exmem, hif.load_memwb, hif.flush_ifid, hif.flush_idex};
    endfunction

    function automatic logic [5:0] cur_in();
        return {hif.stall_lw, hif.br_mispredict, hif.icache_req,
                hif.icache_resp, hif.dcache_req, hif.dcache_resp};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 3; i++) cnt[i] = 0;
        m_wait = 0;
        m_to   = 1'b0;
    endtask

    task automatic drive(input logic [5:0] v, input bit pc);
        {hif.stall_lw, hif.br_mispredict, hif.icache_req, hif.icache_resp,
         hif.dcache_req, hif.dcache_resp} = v;
        hif.perf_clr = pc;
    endtask

    // Entered and left at posedge+1; outputs sampled mid-cycle, state after the edge.
    task automatic step(input logic [5:0] v, input bit pc, input bit use_exp,
                        input logic [7:0] exp, input string nm);
        int k;
        drive(v, pc);
        #3;
        k = kind_of(cur_in());
        if (use_exp) chk(nm, dut_ctrl(), exp);
        chk("ctrl_model", dut_ctrl(), ctrl_of(k));
        @(posedge clk);
        if (pc) begin
            for (int i = 1; i <= 3; i++) cnt[i] = 0;
        end else if (k <= 3 && cnt[k] < CMAX) begin
            cnt[k]++;
        end
        m_wait = (k == 1) ? m_wait + 1 : 0;
        if (m_wait >= TIMEOUT) m_to = 1'b1;
        #1;
        chk("mem_stall_cnt", hif.mem_stall_cnt, cnt[1]);
        chk("flush_cnt", hif.flush_cnt, cnt[2]);
        chk("lu_stall_cnt", hif.lu_stall_cnt, cnt[3]);
        chk("mem_timeout", hif.mem_timeout, m_to);
    endtask

    task automatic idle(input bit pc);
        step(6'b000000, pc, 1'b0, 8'h00, "");
    endtask

    initial begin
        tbl[0] = '{6'b000000, C_RUN};
        tbl[1] = '{6'b100000, C_BUBBLE};
        tbl[2] = '{6'b110000, C_REDIR};
        tbl[3] = '{6'b010000, C_REDIR};
        tbl[4] = '{6'b101000, C_FREEZE};
        tbl[5] = '{6'b101100, C_BUBBLE};
        tbl[6] = '{6'b010010, C_FREEZE};
        tbl[7] = '{6'b010011, C_REDIR};
        tbl[8] = '{6'b001111, C_RUN};
        tbl[9] = '{6'b110110, C_FREEZE};

        drive(6'b000000, 1'b0);
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ctrl", dut_ctrl(), 8'h00);
        chk("rst_lu", hif.lu_stall_cnt, 0);
        chk("rst_ms", hif.mem_stall_cnt, 0);
        chk("rst_fl", hif.flush_cnt, 0);
        chk("rst_to", hif.mem_timeout, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            step(tbl[i].in, 1'b0, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));

        // Single load-use bubble
        idle(1'b1);
        step(6'b100000, 1'b0, 1'b1, C_BUBBLE, "t1_bubble");
        chk("t1_lu", hif.lu_stall_cnt, 1);

        // Mispredict wins over load-use
        idle(1'b1);
        step(6'b110000, 1'b0, 1'b1, C_REDIR, "t2_redirect");
        chk("t2_fl", hif.flush_cnt, 1);
        chk("t2_lu", hif.lu_stall_cnt, 0);

        // Mispredict pending through a 5-cycle dcache freeze
        idle(1'b1);
        for (int i = 0; i < 5; i++)
            step(6'b010010, 1'b0, 1'b1, C_FREEZE, $sformatf("t3_freeze%0d", i));
        step(6'b010011, 1'b0, 1'b1, C_REDIR, "t3_redirect");
        chk("t3_ms", hif.mem_stall_cnt, 5);
        chk("t3_fl", hif.flush_cnt, 1);
        idle(1'b0);

        // Counter saturation and clear-over-increment
        idle(1'b1);
        for (int i = 0; i < 20; i++)
            step(6'b100000, 1'b0, 1'b0, 8'h00, "");
        chk("t5_sat", hif.lu_stall_cnt, 15);
        step(6'b100000, 1'b1, 1'b1, C_BUBBLE, "t5_clr_ctrl");
        chk("t5_clr", hif.lu_stall_cnt, 0);

        // Watchdog sets on the 8th consecutive busy cycle and sticks
        idle(1'b1);
        for (int i = 0; i < 7; i++)
            step(6'b001000, 1'b0, 1'b0, 8'h00, "");
        chk("t4_pre", hif.mem_timeout, 0);
        step(6'b001000, 1'b0, 1'b0, 8'h00, "");
        chk("t4_set", hif.mem_timeout, 1);
        step(6'b001100, 1'b0, 1'b1, C_RUN, "t4_resp_ctrl");
        chk("t4_hold_resp", hif.mem_timeout, 1);
        idle(1'b1);
        chk("t4_hold_clr", hif.mem_timeout, 1);

        // Reset mid-freeze with a redirect pending
        step(6'b010010, 1'b0, 1'b1, C_FREEZE, "t6_freeze0");
        step(6'b010010, 1'b0, 1'b1, C_FREEZE, "t6_freeze1");
        drive(6'b010010, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", dut_ctrl(), 8'h00);
        chk("t6_rst_ms", hif.mem_stall_cnt, 0);
        chk("t6_rst_to", hif.mem_timeout, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(6'b000000, 1'b0, 1'b1, C_RUN, "t6_release");
        chk("t6_fl", hif.flush_cnt, 0);

        for (int n = 0; n < 500; n++) begin
            logic [5:0] v;
            bit pc;
            v[5] = ($urandom_range(0, 2) == 0);
            v[4] = ($urandom_range(0, 3) == 0);
            v[3] = ($urandom_range(0, 3) == 0);
            v[2] = $urandom_range(0, 1) != 0;
            v[1] = ($urandom_range(0, 3) == 0);
            v[0] = $urandom_range(0, 1) != 0;
            pc   = ($urandom_range(0, 31) == 0);
            if (n % 100 == 50) begin
                for (int j = 0; j < TIMEOUT + 2; j++)
                    step(6'b000010, 1'b0, 1'b0, 8'h00, "");
            end
            step(v, pc, 1'b0, 8'h00, "");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
